// File: rtl/unified_mem_if.sv
// Bus bundle between the core and the unified memory controller: one fetch
// port (rom_*) and one load/store port (ram_*) sharing a single RAM.
//
// Handshake: a port raises its *_ce_i with address (and store data/sel/we)
// and holds everything stable until it sees its 1-cycle ack pulse
// (inst_ack_o / data_ack_o). The controller captures the request at the edge
// it grants it; a ce still high in the cycle after the ack is a new request.
interface unified_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    rom_ce_i;
  logic [ADDR_WIDTH-1:0]   rom_addr_i;
  logic [DATA_WIDTH-1:0]   rom_data_o;
  logic                    inst_ack_o;
  logic                    ram_ce_i;
  logic                    ram_write_enable_i;
  logic [DATA_WIDTH/8-1:0] ram_sel_i;
  logic [ADDR_WIDTH-1:0]   ram_addr_i;
  logic [DATA_WIDTH-1:0]   ram_data_i;
  logic [DATA_WIDTH-1:0]   ram_data_o;
  logic                    data_ack_o;
  logic                    stall_o;

  // Core side
  modport master (
    output rom_ce_i, rom_addr_i, ram_ce_i, ram_write_enable_i,
           ram_sel_i, ram_addr_i, ram_data_i,
    input  rom_data_o, inst_ack_o, ram_data_o, data_ack_o, stall_o
  );

  // Controller side
  modport slave (
    input  rom_ce_i, rom_addr_i, ram_ce_i, ram_write_enable_i,
           ram_sel_i, ram_addr_i, ram_data_i,
    output rom_data_o, inst_ack_o, ram_data_o, data_ack_o, stall_o
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Unified single-port memory controller. One word-addressed RAM serves both
// the fetch port and the load/store port. A request is granted in IDLE,
// optionally waits WAIT_CYCLES edges, performs the access, then acks for one
// cycle in ACK. The FSM state is visible on dbg_state_o.
module unified_mem_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int DEPTH_LOG2    = 10,
  parameter int WAIT_CYCLES   = 1,
  parameter int DATA_PRIORITY = 1
) (
  input  logic               clk,
  input  logic               rst,
  unified_mem_if.slave       bus,
  output logic [1:0]         dbg_state_o
);

  localparam int         SEL_W   = DATA_WIDTH / 8;
  localparam int         WORDS   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

  state_t                  state_q, state_d;
  grant_t                  grant_q, grant_d;
  grant_t                  last_q, last_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   rom_data_q;
  logic [DATA_WIDTH-1:0]   ram_data_q;
  logic [DATA_WIDTH-1:0]   mem_q [WORDS];

  // Access performed at the coming edge (either straight from the inputs
  // when there are no wait states, or from the captured request).
  logic                    acc_en;
  grant_t                  acc_gnt;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic                    acc_we;
  logic [SEL_W-1:0]        acc_sel;
  logic [DATA_WIDTH-1:0]   acc_wdata;

  logic                    pick_data;
  logic [DEPTH_LOG2-1:0]   new_idx;
  logic                    new_we;
  logic                    unused_addr;

  // Only the word-index bits of the byte addresses matter; the rest alias.
  assign unused_addr = ^{bus.rom_addr_i, bus.ram_addr_i};

  // Arbitration: data wins unless round-robin mode and data was granted last.
  always_comb begin
    pick_data = bus.ram_ce_i &&
                (!bus.rom_ce_i || (DATA_PRIORITY != 0) || (last_q == GNT_INST));
    new_idx   = pick_data ? bus.ram_addr_i[DEPTH_LOG2+1:2]
                          : bus.rom_addr_i[DEPTH_LOG2+1:2];
    new_we    = pick_data && bus.ram_write_enable_i;
  end

  // Next-state logic: grant/capture in IDLE, count down in WAIT, ack once.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    we_d      = we_q;
    acc_en    = 1'b0;
    acc_gnt   = grant_q;
    acc_idx   = idx_q;
    acc_we    = we_q;
    acc_sel   = sel_q;
    acc_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.rom_ce_i || bus.ram_ce_i) begin
          grant_d = pick_data ? GNT_DATA : GNT_INST;
          last_d  = grant_d;
          idx_d   = new_idx;
          wdata_d = bus.ram_data_i;
          sel_d   = bus.ram_sel_i;
          we_d    = new_we;
          if (WAIT_CYCLES == 0) begin
            acc_en    = 1'b1;
            acc_gnt   = grant_d;
            acc_idx   = new_idx;
            acc_we    = new_we;
            acc_sel   = bus.ram_sel_i;
            acc_wdata = bus.ram_data_i;
            state_d   = ACK;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_en  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control/request registers and read-data holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= GNT_INST;
      last_q     <= GNT_INST;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      rom_data_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      if (acc_en && !acc_we) begin
        if (acc_gnt == GNT_DATA) begin
          ram_data_q <= mem_q[acc_idx];
        end else begin
          rom_data_q <= mem_q[acc_idx];
        end
      end
    end
  end

  // RAM byte-lane writes; contents survive reset, but nothing commits in it.
  always_ff @(posedge clk) begin
    if (!rst && acc_en && acc_we) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (acc_sel[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.rom_data_o = rom_data_q;
  assign bus.ram_data_o = ram_data_q;
  assign bus.inst_ack_o = (state_q == ACK) && (grant_q == GNT_INST);
  assign bus.data_ack_o = (state_q == ACK) && (grant_q == GNT_DATA);
  assign bus.stall_o    = (bus.ram_ce_i && !bus.data_ack_o) ||
                          (bus.rom_ce_i && !bus.inst_ack_o);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl. Three instances cover the parameter
// points of interest: A (no wait, data priority), B (3 waits, round-robin),
// C (2 waits, data priority). One set of drive signals is steered to the
// instance selected by sel_dut; inputs change #1 after posedge, outputs are
// sampled on negedge.
module tb_unified_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel_dut = 0;

  logic        rom_ce, ram_ce, ram_we;
  logic [31:0] rom_addr, ram_addr, ram_wdata;
  logic [3:0]  ram_sel;

  logic [31:0] rom_data, ram_data;
  logic        inst_ack, data_ack, stall;
  logic [1:0]  dbg;
  logic [1:0]  st_a, st_b, st_c;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic        stall_tr [0:15];
  int          lat;

  // clock
  always #5 clk = ~clk;

  unified_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if_a ();
  unified_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if_b ();
  unified_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if_c ();

  assign if_a.rom_ce_i = rom_ce && (sel_dut == 0);
  assign if_a.ram_ce_i = ram_ce && (sel_dut == 0);
  assign if_b.rom_ce_i = rom_ce && (sel_dut == 1);
  assign if_b.ram_ce_i = ram_ce && (sel_dut == 1);
  assign if_c.rom_ce_i = rom_ce && (sel_dut == 2);
  assign if_c.ram_ce_i = ram_ce && (sel_dut == 2);
  assign if_a.rom_addr_i = rom_addr;
  assign if_b.rom_addr_i = rom_addr;
  assign if_c.rom_addr_i = rom_addr;
  assign if_a.ram_addr_i = ram_addr;
  assign if_b.ram_addr_i = ram_addr;
  assign if_c.ram_addr_i = ram_addr;
  assign if_a.ram_data_i = ram_wdata;
  assign if_b.ram_data_i = ram_wdata;
  assign if_c.ram_data_i = ram_wdata;
  assign if_a.ram_sel_i = ram_sel;
  assign if_b.ram_sel_i = ram_sel;
  assign if_c.ram_sel_i = ram_sel;
  assign if_a.ram_write_enable_i = ram_we;
  assign if_b.ram_write_enable_i = ram_we;
  assign if_c.ram_write_enable_i = ram_we;

  unified_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10),
                     .WAIT_CYCLES(0), .DATA_PRIORITY(1))
    u_a (.clk(clk), .rst(rst), .bus(if_a), .dbg_state_o(st_a));
  unified_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10),
                     .WAIT_CYCLES(3), .DATA_PRIORITY(0))
    u_b (.clk(clk), .rst(rst), .bus(if_b), .dbg_state_o(st_b));
  unified_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10),
                     .WAIT_CYCLES(2), .DATA_PRIORITY(1))
    u_c (.clk(clk), .rst(rst), .bus(if_c), .dbg_state_o(st_c));

  // observe the selected instance
  always_comb begin
    rom_data = if_a.rom_data_o;
    ram_data = if_a.ram_data_o;
    inst_ack = if_a.inst_ack_o;
    data_ack = if_a.data_ack_o;
    stall    = if_a.stall_o;
    dbg      = st_a;
    case (sel_dut)
      1: begin
        rom_data = if_b.rom_data_o;
        ram_data = if_b.ram_data_o;
        inst_ack = if_b.inst_ack_o;
        data_ack = if_b.data_ack_o;
        stall    = if_b.stall_o;
        dbg      = st_b;
      end
      2: begin
        rom_data = if_c.rom_data_o;
        ram_data = if_c.ram_data_o;
        inst_ack = if_c.inst_ack_o;
        data_ack = if_c.data_ack_o;
        stall    = if_c.stall_o;
        dbg      = st_c;
      end
      default: ;
    endcase
  end

  // scoreboard compare
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    rom_ce = 1'b0;
    ram_ce = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request on one port; returns the ack latency in negedges after the
  // request was driven (index 0 = the request cycle), or -1 on timeout.
  task automatic access(input bit is_fetch, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] sel,
                        output int lat_o);
    @(posedge clk);
    #1;
    if (is_fetch) begin
      rom_ce = 1'b1; rom_addr = addr;
    end else begin
      ram_ce = 1'b1; ram_we = we; ram_addr = addr; ram_wdata = wd; ram_sel = sel;
    end
    lat_o = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 16) stall_tr[i] = stall;
      if (is_fetch ? inst_ack : data_ack) begin
        lat_o = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    rom_ce = 1'b0;
    ram_ce = 1'b0;
  endtask

  // Both ports request together (loads/fetch); grant order is checked
  // against exp_q and the spacing of acks against w+2. Requests stay high.
  task automatic hold_both(input int n, input int w);
    int prev;
    int got;
    logic [31:0] e;
    @(posedge clk);
    #1;
    rom_ce = 1'b1; rom_addr = 32'h10;
    ram_ce = 1'b1; ram_we = 1'b0; ram_addr = 32'h20;
    prev = -1;
    got  = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge clk);
      if (data_ack || inst_ack) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check_eq("grant_order", {31'd0, data_ack}, e);
        if (prev >= 0) check_eq("grant_gap", i - prev, w + 2);
        prev = i;
        got++;
      end
    end
    if (got < n) check_eq("hold_timeout", got, n);
  endtask

  initial begin
    bit seen;
    rom_ce = 0; ram_ce = 0; ram_we = 0;
    rom_addr = 0; ram_addr = 0; ram_wdata = 0; ram_sel = 0;
    do_reset(3);

    // reset state of every instance
    for (int d = 0; d < 3; d++) begin
      sel_dut = d;
      @(negedge clk);
      check_eq("rst_state", dbg, 0);
      check_eq("rst_inst_ack", inst_ack, 0);
      check_eq("rst_data_ack", data_ack, 0);
      check_eq("rst_rom_data", rom_data, 0);
      check_eq("rst_ram_data", ram_data, 0);
    end

    // ---- instance A: WAIT_CYCLES=0, data priority ----
    sel_dut = 0;
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
    check_eq("w0_store_lat", lat, 1);
    access(0, 0, 32'h10, 32'h0, 4'h0, lat);
    check_eq("w0_load_lat", lat, 1);
    check_eq("w0_load_data", ram_data, 32'hDEADBEEF);

    access(0, 1, 32'h20, 32'h11223344, 4'hF, lat);
    access(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, lat);
    check_eq("write_keeps_rdata", ram_data, 32'hDEADBEEF);
    access(0, 0, 32'h20, 32'h0, 4'h0, lat);
    check_eq("byte_lanes", ram_data, 32'h11BB33DD);

    access(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, lat);
    check_eq("sel0_lat", lat, 1);
    access(0, 0, 32'h20, 32'h0, 4'h0, lat);
    check_eq("sel0_no_change", ram_data, 32'h11BB33DD);

    access(0, 1, 32'h1004, 32'hCAFEF00D, 4'hF, lat);
    access(0, 0, 32'h0004, 32'h0, 4'h0, lat);
    check_eq("alias_upper", ram_data, 32'hCAFEF00D);
    access(0, 0, 32'h0007, 32'h0, 4'h0, lat);
    check_eq("alias_low_bits", ram_data, 32'hCAFEF00D);

    access(1, 0, 32'h10, 32'h0, 4'h0, lat);
    check_eq("w0_fetch_lat", lat, 1);
    check_eq("w0_fetch_data", rom_data, 32'hDEADBEEF);
    check_eq("fetch_keeps_rdata", ram_data, 32'hCAFEF00D);

    // data priority: three data acks while both request, inst only after
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    hold_both(3, 0);
    check_eq("prio_ram_data", ram_data, 32'h11BB33DD);
    @(posedge clk);
    #1 ram_ce = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inst_ack) begin seen = 1; break; end
    end
    check_eq("prio_inst_after_drop", seen, 1);
    @(posedge clk);
    #1 rom_ce = 1'b0;

    // ---- instance B: WAIT_CYCLES=3, round-robin ----
    sel_dut = 1;
    access(0, 1, 32'h0, 32'h5A5A0001, 4'hF, lat);
    check_eq("w3_store_lat", lat, 4);
    access(1, 0, 32'h0, 32'h0, 4'h0, lat);
    check_eq("w3_fetch_lat", lat, 4);
    for (int i = 0; i < 5; i++) check_eq("w3_stall", stall_tr[i], (i < 4) ? 1 : 0);
    check_eq("w3_fetch_data", rom_data, 32'h5A5A0001);

    do_reset(2);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    hold_both(4, 3);
    @(posedge clk);
    #1;
    rom_ce = 1'b0;
    ram_ce = 1'b0;
    check_eq("rr_exp_empty", exp_q.size(), 0);

    // ---- instance C: WAIT_CYCLES=2, reset during WAIT ----
    sel_dut = 2;
    access(0, 1, 32'h40, 32'h0, 4'hF, lat);
    check_eq("w2_store_lat", lat, 3);
    @(posedge clk);
    #1;
    ram_ce = 1'b1; ram_we = 1'b1; ram_addr = 32'h40;
    ram_wdata = 32'h12345678; ram_sel = 4'hF;
    @(posedge clk);
    #1;
    check_eq("pre_rst_in_wait", dbg, 1);
    rst = 1'b1;
    ram_ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_no_ack", data_ack, 0);
    end
    check_eq("rst_back_idle", dbg, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    access(0, 0, 32'h40, 32'h0, 4'h0, lat);
    check_eq("w2_load_lat", lat, 3);
    check_eq("rst_write_dropped", ram_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Shared single-port memory controller for the SoC top level.
- Replaces the separate instruction ROM and data RAM with one word-addressed RAM that serves both the fetch port and the load/store port of the core.
- Arbitrates between the two ports, inserts a configurable number of wait states, and drives a stall back to the core while any request is pending.

Parameters:
- DATA_WIDTH, 32, width of a memory word; must be a multiple of 8.
- ADDR_WIDTH, 32, width of the byte address on both ports.
- DEPTH_LOG2, 10, log2 of the number of words in the RAM.
- WAIT_CYCLES, 1, extra cycles per access; legal range 0..15.
- DATA_PRIORITY, 1, arbitration mode: 1 = data port always wins; 0 = round-robin on the last grant.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rom_ce_i  in  1  fetch request.
- rom_addr_i  in  ADDR_WIDTH  fetch byte address.
- rom_data_o  out  DATA_WIDTH  fetched word.
- inst_ack_o  out  1  fetch complete; 1-cycle pulse.
- ram_ce_i  in  1  load/store request.
- ram_write_enable_i  in  1  1 = store, 0 = load.
- ram_sel_i  in  DATA_WIDTH/8  byte-lane enables for stores.
- ram_addr_i  in  ADDR_WIDTH  load/store byte address.
- ram_data_i  in  DATA_WIDTH  store data.
- ram_data_o  out  DATA_WIDTH  load data.
- data_ack_o  out  1  load/store complete; 1-cycle pulse.
- stall_o  out  1  pipeline stall to the core.

Behaviour:
- Reset: state=IDLE, inst_ack_o=0, data_ack_o=0, rom_data_o=0, ram_data_o=0, last-grant=INST, wait counter=0. RAM contents are not cleared.
- Word index = addr[DEPTH_LOG2+1:2]. Upper bits and addr[1:0] are ignored, so addresses alias modulo the RAM size.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise grant per arbitration and register the grant, address, write data, sel and write enable at this edge. Input changes after acceptance are ignored.
  - If WAIT_CYCLES=0: perform the access at this edge and go to ACK.
  - If WAIT_CYCLES>0: load counter=WAIT_CYCLES and go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter equals 1: perform the access and go to ACK.
- ACK:
  - Assert the ack of the granted port for exactly one cycle.
  - Go to IDLE unconditionally; no request is accepted in ACK.
- Timing:
  - Ack is high in cycle N+WAIT_CYCLES+1 for a request sampled at edge N.
  - Peak throughput is one access per WAIT_CYCLES+2 cycles.
- Access:
  - Read: registered data goes to rom_data_o or ram_data_o and is held until the next read on that port.
  - Write: byte lane i is written only when ram_sel_i[i]=1; ram_data_o is unchanged.
  - A write with sel=0 completes and acks with no memory change.
  - A fetch never writes.
- Arbitration:
  - DATA_PRIORITY=1: the data port wins any simultaneous request.
  - DATA_PRIORITY=0: on a simultaneous request, grant the port not granted last; last-grant updates on every grant.
- stall_o (combinational) = (ram_ce_i & ~data_ack_o) | (rom_ce_i & ~inst_ack_o).
  - The core holds its requests stable while stalled.
  - A request still asserted in the cycle after its ack is treated as a new access.
- Reset mid-access: reset takes priority in any state.
  - A write pending in WAIT is not committed.
  - Acks drop to 0 in the next cycle.
- WAIT_CYCLES outside 0..15 is illegal; the wait counter is 4 bits.

Test Plan:
- WAIT_CYCLES=0: store 0xDEADBEEF to 0x10 with sel=4'hF, then load 0x10 → data_ack_o high 1 cycle after each acceptance; ram_data_o=0xDEADBEEF.
- Byte lanes: mem[0x20]=0x11223344; store 0xAABBCCDD with sel=4'b0101; load → 0x11BB33DD.
- WAIT_CYCLES=3, fetch from 0x0 → inst_ack_o in cycle N+4; stall_o high in cycles N..N+3, low in N+4; rom_data_o is the preloaded word.
- Simultaneous rom_ce_i and ram_ce_i held high:
  - DATA_PRIORITY=1 → data acked first, then data again while ram_ce_i stays high; inst is not granted until ram_ce_i drops.
  - DATA_PRIORITY=0 → grants alternate starting with DATA (last-grant=INST after reset).
- DEPTH_LOG2=10: store to 0x1004 then load 0x0004 → same word (aliasing).
- WAIT_CYCLES=2: store 0x12345678 to 0x40 (old value 0x0); assert rst while in WAIT → no ack; after reset, load 0x40 returns 0x0.
